// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues word-aligned fetches and buffers in-order responses for decode.
// Latency: response -> inst_valid 1 cycle (0 cycles when IFQ_BYPASS_EN is defined and the queue is empty).
// Backpressure: fetches are credit-limited so count+pending never exceeds DEPTH; decode stalls via inst_ready.
// Optional feature macro: IFQ_BYPASS_EN (empty-queue response bypass to decode).
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q,   rsp_pc_d;
    logic [CW-1:0] count_q,    count_d;
    logic [CW-1:0] pending_q,  pending_d;
    logic [CW-1:0] drop_q,     drop_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;

    logic [31:0] pc_mem  [DEPTH];
    logic [31:0] ins_mem [DEPTH];

    logic [CW:0] occupancy;
    logic        credit_ok;
    logic        req_fire;
    logic        rsp_keep;
    logic        rsp_drop;
    logic        fifo_has;
    logic        bypass_vld;
    logic        pop_fire;
    logic        fifo_pop;
    logic        fifo_push;
    logic        unused_ok;

    // Low address bits of a redirect target are discarded by alignment.
    assign unused_ok = ^redirect_pc[1:0];

    // Fetch issue, response classification and decode-side handshake.
    always_comb begin
        occupancy      = {1'b0, count_q} + {1'b0, pending_q};
        credit_ok      = occupancy < LIMIT;
        imem_req_valid = !reset && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        // Responses in a redirect cycle are always stale; drop_q counts older stale ones.
        rsp_keep = imem_rsp_valid && !reset && !redirect_valid && (drop_q == '0);
        rsp_drop = imem_rsp_valid && !reset && !redirect_valid && (drop_q != '0);
        fifo_has = (count_q != '0);

`ifdef IFQ_BYPASS_EN
        bypass_vld = rsp_keep && !fifo_has;
`else
        bypass_vld = 1'b0;
`endif

        inst_valid  = !reset && !redirect_valid && (fifo_has || bypass_vld);
        instruction = 32'h0;
        inst_pc     = 32'h0;
        if (inst_valid) begin
            instruction = fifo_has ? ins_mem[rd_ptr_q] : imem_rsp_data;
            inst_pc     = fifo_has ? pc_mem[rd_ptr_q]  : rsp_pc_q;
        end

        pop_fire  = inst_valid && inst_ready;
        fifo_pop  = pop_fire && fifo_has;
        // A bypassed word consumed in its arrival cycle never occupies a slot.
        fifo_push = rsp_keep && !(bypass_vld && inst_ready);
    end

    // Next-state: redirect flushes the queue and converts in-flight requests into drops.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        pending_d  = pending_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            pending_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_d     = drop_q + pending_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            pending_d = pending_q + CW'(req_fire) - CW'(rsp_keep);
            drop_d    = drop_q - CW'(rsp_drop);
            count_d   = count_q + CW'(fifo_push) - CW'(fifo_pop);
            if (fifo_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            pending_q  <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage; contents are only observed while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (fifo_push && !reset) begin
            pc_mem[wr_ptr_q]  <= rsp_pc_q;
            ins_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory requests tagged with a redirect epoch; a response
    // is useful only if its epoch is current and it does not land in a redirect cycle.
    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    req_t        inflight[$];
    ent_t        mfifo[$];
    logic [31:0] acc[$];
    logic [31:0] pops[$];
    int          cyc, epoch, lat_min, lat_max;
    logic [31:0] m_fetch;
    int          n_pass, n_chk;

    bit          c_redir, c_iready, c_rready, c_keep, c_byp;
    logic [31:0] c_tgt;
    bit          exp_req_valid, exp_inst_valid;
    logic [31:0] exp_instr, exp_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    function automatic int cur_pending();
        int p = 0;
        foreach (inflight[i]) if (inflight[i].epoch == epoch) p++;
        return p;
    endfunction

    // Drive one cycle of inputs at the falling edge and compute expected outputs.
    task automatic drive(input bit redir, input logic [31:0] tgt, input bit iready, input bit rready);
        @(negedge clk);
        c_redir = redir; c_tgt = tgt; c_iready = iready; c_rready = rready;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(inflight[0].addr);
        end
        redirect_valid = redir; redirect_pc = tgt; inst_ready = iready; imem_req_ready = rready;
        exp_req_valid = !redir && ((mfifo.size() + cur_pending()) < DEPTH);
        c_keep = imem_rsp_valid && !redir && (inflight[0].epoch == epoch);
        c_byp  = 1'b0;
`ifdef IFQ_BYPASS_EN
        c_byp = c_keep && (mfifo.size() == 0);
`endif
        exp_inst_valid = !redir && (mfifo.size() > 0 || c_byp);
        exp_instr = 32'h0; exp_pc = 32'h0;
        if (exp_inst_valid) begin
            if (mfifo.size() > 0) begin
                exp_instr = mfifo[0].ins; exp_pc = mfifo[0].pc;
            end else begin
                exp_instr = imem_rsp_data; exp_pc = inflight[0].addr;
            end
        end
        #1;
    endtask

    // Advance the reference model across the rising edge.
    task automatic commit();
        req_t r;
        bit   popped, byp_taken;
        @(posedge clk);
        popped    = exp_inst_valid && c_iready;
        byp_taken = c_byp && popped;
        if (popped) begin
            pops.push_back(exp_pc);
            if (!c_byp) void'(mfifo.pop_front());
        end
        if (imem_rsp_valid) begin
            r = inflight.pop_front();
            if (c_keep && !byp_taken) mfifo.push_back('{r.addr, mem_word(r.addr)});
        end
        if (exp_req_valid && c_rready) begin
            inflight.push_back('{m_fetch, epoch, cyc + $urandom_range(lat_max, lat_min)});
            acc.push_back(m_fetch);
            m_fetch = m_fetch + 32'd4;
        end
        if (c_redir) begin
            mfifo.delete();
            epoch++;
            m_fetch = {c_tgt[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom; inst_ready = 1'($urandom);
            redirect_valid = 1'($urandom); redirect_pc = $urandom;
            #1;
            if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); else n_pass++;
            n_chk++;
            if (imem_req_addr !== RPC) $display("FAIL reset_addr got=%h exp=%h", imem_req_addr, RPC); else n_pass++;
            n_chk++;
            if ({inst_valid, instruction, inst_pc} !== 65'h0)
                $display("FAIL reset_inst got=%b/%h/%h exp=0/0/0", inst_valid, instruction, inst_pc);
            else n_pass++;
            n_chk++;
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b0;
        reset = 1'b0;
        cyc = 0; epoch = 0; m_fetch = RPC;
    endtask

    task automatic test_fetch_order();
        logic [31:0] want[4];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0; want[3] = 32'h4;
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1);
            if (imem_req_valid !== exp_req_valid) $display("FAIL order_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req_valid); else n_pass++;
            n_chk++;
            if (imem_req_addr !== m_fetch) $display("FAIL order_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch); else n_pass++;
            n_chk++;
            if (inst_valid !== exp_inst_valid) $display("FAIL order_inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_inst_valid); else n_pass++;
            n_chk++;
            if ({instruction, inst_pc} !== {exp_instr, exp_pc}) $display("FAIL order_inst cyc=%0d got=%h@%h exp=%h@%h", cyc, instruction, inst_pc, exp_instr, exp_pc); else n_pass++;
            n_chk++;
            commit();
        end
        for (int k = 0; k < 4; k++) begin
            if (acc.size() <= k || acc[k] !== want[k]) $display("FAIL order_issue_seq k=%0d got=%h exp=%h", k, (acc.size() > k) ? acc[k] : 32'hx, want[k]); else n_pass++;
            n_chk++;
            if (pops.size() <= k || pops[k] !== want[k]) $display("FAIL order_pop_seq k=%0d got=%h exp=%h", k, (pops.size() > k) ? pops[k] : 32'hx, want[k]); else n_pass++;
            n_chk++;
        end
    endtask

    task automatic test_backpressure();
        int full_seen;
        lat_min = 1; lat_max = 3; full_seen = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 32'h0, (i >= 18), 1'b1);
            if (mfifo.size() == DEPTH) full_seen++;
            if (imem_req_valid !== exp_req_valid) $display("FAIL bp_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req_valid); else n_pass++;
            n_chk++;
            if (imem_req_addr !== m_fetch) $display("FAIL bp_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch); else n_pass++;
            n_chk++;
            if (inst_valid !== exp_inst_valid) $display("FAIL bp_inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_inst_valid); else n_pass++;
            n_chk++;
            if ({instruction, inst_pc} !== {exp_instr, exp_pc}) $display("FAIL bp_inst cyc=%0d got=%h@%h exp=%h@%h", cyc, instruction, inst_pc, exp_instr, exp_pc); else n_pass++;
            n_chk++;
            commit();
        end
        if (full_seen == 0) $display("FAIL bp_queue_fill got=%0d full cycles exp>0", full_seen); else n_pass++;
        n_chk++;
    endtask

    task automatic test_redirect();
        int k;
        bit iready;
        lat_min = 3; lat_max = 3;
        drive(1'b1, 32'h40, 1'b0, 1'b1);
        if (inst_valid !== 1'b0) $display("FAIL redir_flush_inst_valid got=%b exp=0", inst_valid); else n_pass++;
        n_chk++;
        commit();
        k = 0;
        while (cur_pending() != 3 && k < 30) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            if (imem_req_valid !== exp_req_valid) $display("FAIL redir_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req_valid); else n_pass++;
            n_chk++;
            if (imem_req_addr !== m_fetch) $display("FAIL redir_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch); else n_pass++;
            n_chk++;
            commit();
            k++;
        end
        if (cur_pending() != 3) $display("FAIL redir_setup_pending got=%0d exp=3", cur_pending()); else n_pass++;
        n_chk++;
        drive(1'b1, 32'h100, 1'b0, 1'b1);
        commit();
        pops.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1);
            if (imem_req_addr !== m_fetch) $display("FAIL redir_addr2 cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch); else n_pass++;
            n_chk++;
            if (inst_valid !== exp_inst_valid) $display("FAIL redir_inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_inst_valid); else n_pass++;
            n_chk++;
            if ({instruction, inst_pc} !== {exp_instr, exp_pc}) $display("FAIL redir_inst cyc=%0d got=%h@%h exp=%h@%h", cyc, instruction, inst_pc, exp_instr, exp_pc); else n_pass++;
            n_chk++;
            commit();
        end
        if (pops.size() == 0 || pops[0] !== 32'h100) $display("FAIL redir_first_pc got=%h exp=00000100", (pops.size() > 0) ? pops[0] : 32'hx); else n_pass++;
        n_chk++;

        // Redirect colliding with a response and a would-be pop.
        lat_min = 1; lat_max = 2;
        k = 0;
        while (!(mfifo.size() > 0 && inflight.size() > 0 && inflight[0].due <= cyc) && k < 200) begin
            iready = 1'($urandom);
            drive(1'b0, 32'h0, iready, 1'b1);
            if ({inst_valid, inst_pc} !== {exp_inst_valid, exp_pc}) $display("FAIL collide_pre cyc=%0d got=%b@%h exp=%b@%h", cyc, inst_valid, inst_pc, exp_inst_valid, exp_pc); else n_pass++;
            n_chk++;
            commit();
            k++;
        end
        if (k >= 200) $display("FAIL collide_setup got=timeout exp=collision within 200 cycles"); else n_pass++;
        n_chk++;
        drive(1'b1, 32'h2000, 1'b1, 1'b1);
        if (imem_rsp_valid !== 1'b1) $display("FAIL collide_rsp_present got=%b exp=1", imem_rsp_valid); else n_pass++;
        n_chk++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) $display("FAIL collide_redirect_cycle got=%b/%b exp=0/0", inst_valid, imem_req_valid); else n_pass++;
        n_chk++;
        commit();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        if (inst_valid !== 1'b0) $display("FAIL collide_next_empty got=%b exp=0", inst_valid); else n_pass++;
        n_chk++;
        if (imem_req_addr !== 32'h2000) $display("FAIL collide_next_addr got=%h exp=00002000", imem_req_addr); else n_pass++;
        n_chk++;
        commit();
    endtask

    task automatic test_random();
        bit          redir;
        logic [31:0] tgt;
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 500; i++) begin
            redir = ($urandom_range(15, 0) == 0);
            tgt   = (i % 7 == 0) ? 32'hFFFF_FFF4 + $urandom_range(3, 0) : $urandom;
            drive(redir, tgt, 1'($urandom), ($urandom_range(9, 0) < 7));
            if (imem_req_valid !== exp_req_valid) $display("FAIL rand_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req_valid); else n_pass++;
            n_chk++;
            if (imem_req_addr !== m_fetch) $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch); else n_pass++;
            n_chk++;
            if (inst_valid !== exp_inst_valid) $display("FAIL rand_inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_inst_valid); else n_pass++;
            n_chk++;
            if ({instruction, inst_pc} !== {exp_instr, exp_pc}) $display("FAIL rand_inst cyc=%0d got=%h@%h exp=%h@%h", cyc, instruction, inst_pc, exp_instr, exp_pc); else n_pass++;
            n_chk++;
            commit();
        end
    endtask

    task automatic test_async_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            commit();
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        if ({imem_req_valid, inst_valid, instruction, inst_pc} !== 66'h0)
            $display("FAIL async_reset_outputs got=%b/%b/%h/%h exp=0/0/0/0", imem_req_valid, inst_valid, instruction, inst_pc);
        else n_pass++;
        n_chk++;
        if (imem_req_addr !== RPC) $display("FAIL async_reset_addr got=%h exp=%h", imem_req_addr, RPC); else n_pass++;
        n_chk++;
        @(posedge clk);
        #1;
        if (inst_valid !== 1'b0) $display("FAIL async_reset_hold got=%b exp=0", inst_valid); else n_pass++;
        n_chk++;
    endtask

    initial begin
        n_pass = 0; n_chk = 0;
        cyc = 0; epoch = 0; m_fetch = RPC; lat_min = 1; lat_max = 1;
        test_reset();
        test_fetch_order();
        test_backpressure();
        test_redirect();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries and the in-flight request limit (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high, with the ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  instruction memory accepts the request.
REQ-008 imem_req_addr  output  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  in-order response valid, one cycle wide, no backpressure.
REQ-010 imem_rsp_data  input  32  response instruction word.
REQ-011 redirect_valid  input  1  branch/jump redirect strobe.
REQ-012 redirect_pc  input  32  redirect target.
REQ-013 inst_valid  output  1  instruction available to decode.
REQ-014 inst_ready  input  1  decode consumes the instruction.
REQ-015 instruction  output  32  head instruction word, 0 when inst_valid=0.
REQ-016 inst_pc  output  32  head instruction address, 0 when inst_valid=0.

Function
REQ-017 The block SHALL hold fetch_pc, rsp_pc, a DEPTH-entry {pc,instr} FIFO, a count, pending (accepted requests not yet answered), and drop (responses to discard), with count, pending and drop each $clog2(DEPTH+1) bits wide.
REQ-018 imem_req_valid SHALL be 1 iff reset=0, redirect_valid=0 and count+pending<DEPTH; imem_req_addr SHALL equal fetch_pc.
REQ-019 On req handshake, fetch_pc SHALL advance by 4 (mod 2^32, wrapping from 32'hFFFF_FFFC to 0) and pending SHALL increment.
REQ-020 A response with drop=0 SHALL push {rsp_pc, imem_rsp_data}, decrement pending and advance rsp_pc by 4.
REQ-021 A response with drop>0 SHALL be discarded and SHALL decrement drop.
REQ-022 Pop SHALL occur on inst_valid and inst_ready; simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH-1 or DEPTH.
REQ-023 The credit rule in REQ-018 SHALL guarantee that no push occurs while full; no overflow path SHALL exist.
REQ-024 In a redirect_valid cycle, inst_valid SHALL be 0 and no pop SHALL occur.
REQ-025 In a redirect_valid cycle, the FIFO SHALL be flushed (count=0) and fetch_pc and rsp_pc SHALL load redirect_pc[31:2],2'b00.
REQ-026 In a redirect_valid cycle, drop SHALL load drop+pending-imem_rsp_valid, pending SHALL load 0, and any response in that cycle SHALL be discarded.
REQ-027 Back-to-back redirects SHALL each take effect; the last one SHALL set the fetch address.
REQ-028 Response-to-inst_valid latency SHALL be 1 cycle (registered FIFO output) unless REQ-033 applies.

Reset
REQ-029 While reset=1, the block SHALL hold fetch_pc=rsp_pc=RESET_PC, count=pending=drop=0, imem_req_valid=0, inst_valid=0, instruction=0 and inst_pc=0.
REQ-030 Responses while reset=1 SHALL be ignored; the instruction memory shares this reset, so no pre-reset response SHALL arrive after reset release.
REQ-031 The first request SHALL issue in the first cycle after reset deasserts, with addr=RESET_PC.

Configuration
REQ-032 The macro IFQ_BYPASS_EN SHALL compile a bypass feature in or out.
REQ-033 With IFQ_BYPASS_EN defined, when count=0 and a non-discarded response arrives, inst_valid SHALL assert in the same cycle with that word and rsp_pc; if inst_ready=1, the word SHALL NOT be written to the FIFO, otherwise it SHALL be pushed normally.
REQ-034 Without IFQ_BYPASS_EN, inst_valid SHALL reflect only FIFO occupancy (count>0).

Verification
REQ-035 Reset release, imem_req_ready=1, 2-cycle memory latency, inst_ready=1 -> addresses 0,4,8,12 issued; inst_pc sequence 0,4,8,... in order.
REQ-036 inst_ready=0 with responses flowing -> count reaches 4, imem_req_valid drops to 0, no data lost; raise inst_ready -> 4 instructions drain in order.
REQ-037 Redirect to 32'h100 with pending=3 -> the next 3 responses are discarded, the next inst_pc is 32'h100, and instructions previously at 0x8/0xC are never presented.
REQ-038 Redirect in the same cycle as a response and a pop -> response dropped, no pop, drop=pending-1, count=0 next cycle.
REQ-039 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 IFQ_BYPASS_EN, empty queue, response 32'h00500093 at pc 0 -> inst_valid=1 in the same cycle; count stays 0 with inst_ready=1.
